// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the caches, the MMU and the cache-to-MMU
// arbiter.
//   arb_state_e : arbiter state (ST_IDLE = waiting for requests,
//                 ST_BUSY = one transaction owns the MMU port)
//   CPU_ADDR_W  : default virtual address width
//   CPU_DATA_W  : default cache-line data width
//   CPU_PTE_W   : default page-table-entry width
package cpu_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_DATA_W = 256;
  localparam int CPU_PTE_W  = 32;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Searches req_i starting at last_i+1 and wrapping modulo N, and returns the
// first set position.
//   req_i    in  N  request vector
//   last_i   in  W  most recently served index (lowest priority now)
//   winner_o out W  selected index (0 when any_o is 0)
//   any_o    out 1  at least one request is set
module rr_pick #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] winner_o,
  output logic         any_o
);

  // Walk offsets from farthest to nearest so the nearest requester after
  // last_i is the final (winning) assignment.
  always_comb begin
    int idx;
    idx      = 0;
    winner_o = '0;
    any_o    = 1'b0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(last_i) + i) % N;
      if (req_i[W'(idx)]) begin
        winner_o = W'(idx);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mem_arbiter.sv
// rr_mem_arbiter: N-channel round-robin arbiter between the cache
// refill/writeback ports and the single MMU virtual-side port. One channel
// owns the MMU port for a whole transaction; ack, fault, read data and page
// entry are returned to that channel only.
//
// Optional feature macro: RR_MEM_ARBITER_TIMEOUT_EN adds a BUSY watchdog of
// TIMEOUT cycles and the sticky timeout_o output.
//
// Ports (channel k occupies bits [k*W +: W] of each flattened bus):
//   clk, rst          clock, asynchronous active-high reset
//   req_addr_i/data_i per-channel address / write data
//   req_rd_i/we_i     per-channel read / write request
//   req_data_o        read data (pass-through of data_i)
//   req_page_ent_o    page entry (pass-through of page_ent_i)
//   req_ack_o         one-hot completion to the granted channel
//   req_fault_o       one-hot page fault (or watchdog) to the granted channel
//   addr_o, data_o    downstream address / write data
//   rd_o, we_o        downstream strobes
//   ack_i             downstream completion
//   hw_page_fault_i   downstream fault, also completes the transaction
//   data_i            downstream read data
//   page_ent_i        downstream page entry
//   timeout_o         sticky watchdog flag (timeout build only)
//   grant_o           current owner, for debug
//
// Handshake: a channel raises rd or we and holds rd/we, address and data
// stable until it sees its req_ack_o bit (req_fault_o comes with an ack).
// The strobe appears one cycle after the request, and a downstream ack_i or
// hw_page_fault_i completes the transaction in the same cycle it is seen.
module rr_mem_arbiter
  import cpu_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int DATA_W  = CPU_DATA_W,
  parameter int PTE_W   = CPU_PTE_W,
  parameter int TIMEOUT = 1023,
  localparam int GW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*ADDR_W-1:0]   req_addr_i,
  input  logic [N_CH*DATA_W-1:0]   req_data_i,
  input  logic [N_CH-1:0]          req_rd_i,
  input  logic [N_CH-1:0]          req_we_i,
  output logic [DATA_W-1:0]        req_data_o,
  output logic [PTE_W-1:0]         req_page_ent_o,
  output logic [N_CH-1:0]          req_ack_o,
  output logic [N_CH-1:0]          req_fault_o,
  output logic [ADDR_W-1:0]        addr_o,
  output logic [DATA_W-1:0]        data_o,
  output logic                     rd_o,
  output logic                     we_o,
  input  logic                     ack_i,
  input  logic                     hw_page_fault_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic [PTE_W-1:0]         page_ent_i,
`ifdef RR_MEM_ARBITER_TIMEOUT_EN
  output logic                     timeout_o,
`endif
  output logic [GW-1:0]            grant_o
);

  arb_state_e      state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [N_CH-1:0] req_v;
  logic [GW-1:0]   pick_w;
  logic            pick_any;
  logic            busy;
  logic            tmo_hit;
  logic            done;

  assign req_v = req_rd_i | req_we_i;
  assign busy  = (state_q == ST_BUSY);

  rr_pick #(.N(N_CH), .W(GW)) u_pick (
    .req_i    (req_v),
    .last_i   (last_q),
    .winner_o (pick_w),
    .any_o    (pick_any)
  );

`ifdef RR_MEM_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // cnt_q reads 1 in the first BUSY cycle, so the watchdog fires in BUSY
  // cycle number TIMEOUT unless the downstream completes in that cycle.
  assign tmo_hit = busy && (cnt_q == CW'(TIMEOUT)) && !ack_i && !hw_page_fault_i;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q | tmo_hit;
    if (!busy && pick_any)
      cnt_d = CW'(1);
    else if (busy && (cnt_q != CW'(TIMEOUT)))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign tmo_hit = 1'b0;

  // TIMEOUT only matters for the watchdog build.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  assign done = busy && (ack_i || hw_page_fault_i || tmo_hit);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_BUSY;
          grant_d = pick_w;
        end
      end
      ST_BUSY: begin
        if (done) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last resets to N_CH-1 so channel 0 has top priority after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_CH - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Downstream side follows the granted channel combinationally, so a
  // requester that drops its request mid-transaction also drops the strobe.
  always_comb begin
    addr_o      = '0;
    data_o      = '0;
    rd_o        = 1'b0;
    we_o        = 1'b0;
    req_ack_o   = '0;
    req_fault_o = '0;
    if (busy) begin
      addr_o = req_addr_i[int'(grant_q)*ADDR_W +: ADDR_W];
      data_o = req_data_i[int'(grant_q)*DATA_W +: DATA_W];
      rd_o   = req_rd_i[grant_q];
      we_o   = req_we_i[grant_q];
    end
    if (done)
      req_ack_o = N_CH'(1) << grant_q;
    if (busy && (hw_page_fault_i || tmo_hit))
      req_fault_o = N_CH'(1) << grant_q;
  end

  assign req_data_o     = data_i;
  assign req_page_ent_o = page_ent_i;
  assign grant_o        = grant_q;

endmodule

// File: doc/rr_mem_arbiter.md
# rr_mem_arbiter

Parametrised N-channel round-robin arbiter for the cache-to-MMU path. It sits between the cache refill/writeback ports (instruction cache, data cache, and future DMA or page-walk clients) and the single MMU virtual-side port. It grants one requester at a time and holds the grant for a whole transaction. Downstream ack, read data, page-table entry and page-fault indication are routed back only to the granted requester.

## Interface
Parameters:
- N_CH, 2: number of requesters (2..8).
- ADDR_W, 32: address width.
- DATA_W, 256: cache-line data width.
- PTE_W, 32: page-table-entry width.
- TIMEOUT, 1023: downstream watchdog limit in cycles. Used only with the timeout feature.

Ports (channel k occupies bits [k*W +: W] of each flattened bus):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_addr_i  in  N_CH*ADDR_W  per-channel address.
- req_data_i  in  N_CH*DATA_W  per-channel write data.
- req_rd_i  in  N_CH  per-channel read request.
- req_we_i  in  N_CH  per-channel write request.
- req_data_o  out  DATA_W  read data, shared by all channels; valid only with that channel's ack.
- req_page_ent_o  out  PTE_W  page entry, shared by all channels; valid only with ack.
- req_ack_o  out  N_CH  one-hot per-channel ack.
- req_fault_o  out  N_CH  one-hot per-channel page fault (or timeout).
- addr_o  out  ADDR_W  downstream address.
- data_o  out  DATA_W  downstream write data.
- rd_o, we_o  out  1  downstream strobes.
- ack_i  in  1  downstream completion.
- hw_page_fault_i  in  1  downstream translation fault; also completes the transaction.
- data_i  in  DATA_W  downstream read data.
- page_ent_i  in  PTE_W  downstream page entry.
- grant_o  out  $clog2(N_CH) (min 1)  current owner, for debug.
- timeout_o  out  1  sticky watchdog flag. Present only with the timeout feature.

## Operation
- Channel request: req_k = req_rd_i[k] | req_we_i[k]. Requesters hold rd/we, address and data stable until they see their ack or fault.
- States:
  - IDLE: downstream rd_o, we_o are 0. If any req_k is set, pick the first requesting channel searching from last+1 upward, wrapping modulo N_CH. Register the winner in grant and go to BUSY. Otherwise stay in IDLE.
  - BUSY: addr_o, data_o, rd_o, we_o are muxed combinationally from the granted channel.
    - On ack_i=1: drive req_ack_o[grant]=1 combinationally in the same cycle, set last←grant, go to IDLE.
    - On hw_page_fault_i=1: drive req_fault_o[grant]=1 and req_ack_o[grant]=1, set last←grant, go to IDLE.
- req_data_o and req_page_ent_o are pass-through from data_i and page_ent_i, unconditionally.
- If the granted requester drops its request while in BUSY (protocol violation), rd_o and we_o follow it to 0. The grant is held until ack or fault.
- ack_i or hw_page_fault_i arriving in IDLE is ignored: no channel is acked.
- Fairness: a requester that has just completed has the lowest priority in the next arbitration. Every requester is served within N_CH grants.

## Timing
- Reset: state=IDLE, grant=0, last=N_CH-1 (so channel 0 wins first), timeout_o=0. All outputs 0 except the data/page-entry pass-through.
- Request to downstream strobe: 1 cycle (arbitration in IDLE, strobe visible in the BUSY cycle).
- Downstream ack to requester ack: 0 cycles (combinational).
- Back-to-back: after a completion there is one IDLE cycle before the next grant. Minimum 2 cycles per transaction plus the downstream latency.
- Reset asserted mid-transaction: grant is abandoned immediately and all strobes drop asynchronously. The downstream side must tolerate an aborted request.

## Configuration
- RR_MEM_ARBITER_TIMEOUT_EN:
  - When defined: a counter runs in BUSY and clears on entry to BUSY. If it reaches TIMEOUT with no ack_i or fault, the arbiter pulses req_fault_o[grant] and req_ack_o[grant] for one cycle, sets timeout_o (sticky until reset), and returns to IDLE. A late ack_i arriving afterwards is ignored.
  - When undefined: no counter and no timeout_o port. BUSY waits indefinitely.

## Structure
- Shared package (cpu_pkg): the arbiter state enum (IDLE, BUSY) and the default width constants for ADDR_W, DATA_W and PTE_W, shared with the caches and the MMU.
- One sub-module, rr_pick: combinational round-robin priority encoder with inputs (req vector, last) and outputs (winner, any). It is reused by the future interrupt controller.

## Test plan
- Single read: after reset, ch0 rd at address 0x1000, downstream acks 3 cycles after rd_o → addr_o=0x1000, req_ack_o=01 in the ack cycle, req_data_o equals the downstream data.
- Contention: ch0 and ch1 request continuously, with ack one cycle after each strobe → grant order 0,1,0,1. No channel is served twice in a row.
- Page fault: ch1 we, with hw_page_fault_i=1 instead of ack_i → req_fault_o=10 and req_ack_o=10, then return to IDLE. The next ch0 request is granted normally.
- Wrap-around with N_CH=4: requests on ch3 and ch1 with last=2 → ch3 is granted first, then ch1.
- Spurious ack in IDLE → req_ack_o stays 0 and the state stays IDLE.
- Reset mid-BUSY, then a new ch1 request → rd_o is 0 during reset, and after reset ch1 is granted with last=N_CH-1. With RR_MEM_ARBITER_TIMEOUT_EN and TIMEOUT=8, a held request with no ack gets its fault pulse on the 8th BUSY cycle and timeout_o=1.
